multi_divid_recover_seq: RTL

Sequential inverse of the team's combinational multiply/divide unit. It takes that unit's result pair (m, r), the operand b and the mode select, and iteratively reconstructs the original operand a. It sits downstream of the arithmetic unit as a self-check and operand-recovery engine: shift-subtract division when undoing a multiply, shift-add multiplication when undoing a divide.

---
 rtl/multi_divid_recover_seq.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/multi_divid_recover_seq.sv
// -----------------------------------------------------------------------------
// multi_divid_recover_seq
//
// Operand-recovery engine that sits behind the combinational multiply/divide
// unit. Given that unit's result pair (m, r), the second operand b and the mode
// select, it iteratively rebuilds the original operand a:
//   signal != 0 : {m,r} was a*b      -> a = {m,r} / b  (restoring division,
//                                       2n iterations, truncation toward zero)
//   signal == 0 : m,r were a/b, a%b  -> a = m*b + r    (shift-add multiply,
//                                       n iterations)
// Latency from the accepted start edge to the done pulse is K+1 cycles
// (K = 2n or n) regardless of operand values, including b == 0.
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   synchronous active-low reset
//   start    in   request, sampled only while idle
//   signal   in   [1:0] mode select (nonzero = undo multiply)
//   m, r, b  in   [n-1:0] signed operands
//   busy     out  high while an operation is in flight
//   done     out  one-cycle pulse when the result outputs update
//   a_out    out  [n-1:0] recovered operand
//   error    out  b was zero
//   overflow out  recovered value does not fit n signed bits
//   inexact  out  (m, r) pair is not consistent with any a
// -----------------------------------------------------------------------------
module multi_divid_recover_seq #(
   parameter int n = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [1:0]   signal,
   input  logic [n-1:0] m,
   input  logic [n-1:0] r,
   input  logic [n-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [n-1:0] a_out,
   output logic         error,
   output logic         overflow,
   output logic         inexact
);

   localparam int CW = $clog2(2*n+1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW-1:0] CNT_MUL = CW'(2*n);
   localparam logic [CW-1:0] CNT_DIV = CW'(n);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   // Magnitude of an n-bit signed value; -2^(n-1) maps to 2^(n-1) unsigned.
   function automatic logic [n-1:0] mag_n(input logic [n-1:0] x);
      return x[n-1] ? (~x + {{(n-1){1'b0}}, 1'b1}) : x;
   endfunction

   // Magnitude of a 2n-bit signed value.
   function automatic logic [2*n-1:0] mag_2n(input logic [2*n-1:0] x);
      return x[2*n-1] ? (~x + {{(2*n-1){1'b0}}, 1'b1}) : x;
   endfunction

   // Apply a sign to a 2n-bit magnitude, producing a 2n+1-bit signed value.
   function automatic logic [2*n:0] apply_sign(input logic neg, input logic [2*n-1:0] mag);
      logic [2*n:0] v;
      v = {1'b0, mag};
      return neg ? (~v + {{(2*n){1'b0}}, 1'b1}) : v;
   endfunction

   // A 2n+1-bit signed value fits n bits when bits [2n:n-1] are all equal.
   function automatic logic fits_n(input logic [2*n:0] x);
      logic [n+1:0] top;
      top = x[2*n:n-1];
      return (&top) | ~(|top);
   endfunction

   state_t          state_q, state_d;
   logic            mode_q, mode_d;        // 1 = undo multiply (division)
   logic            neg_q, neg_d;          // sign of quotient / product
   logic            bzero_q, bzero_d;
   logic [n-1:0]    bmag_q, bmag_d;
   logic [n-1:0]    r_q, r_d;              // remainder kept for divide undo
   logic [2*n-1:0]  shf_q, shf_d;          // dividend in / quotient out, or multiplier
   logic [n:0]      rem_q, rem_d;          // partial remainder
   logic [2*n-1:0]  acc_q, acc_d;          // product accumulator
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [n-1:0]    a_q, a_d;
   logic            err_q, err_d;
   logic            ovf_q, ovf_d;
   logic            inx_q, inx_d;

   logic [n:0]      trial_s;
   logic [2*n:0]    quo_s;
   logic [2*n:0]    sum_s;
   logic [n-1:0]    rmag_s;

   // Datapath helpers shared by the RUN and FIN steps.
   always_comb begin
      trial_s = {rem_q[n-1:0], shf_q[2*n-1]};
      quo_s   = apply_sign(neg_q, shf_q);
      sum_s   = apply_sign(neg_q, acc_q) + {{(n+1){r_q[n-1]}}, r_q};
      rmag_s  = mag_n(r_q);
   end

   // Next-state and output logic for IDLE -> RUN -> FIN.
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      neg_d   = neg_q;
      bzero_d = bzero_q;
      bmag_d  = bmag_q;
      r_d     = r_q;
      shf_d   = shf_q;
      rem_d   = rem_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      a_d     = a_q;
      err_d   = err_q;
      ovf_d   = ovf_q;
      inx_d   = inx_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               mode_d  = |signal;
               neg_d   = m[n-1] ^ b[n-1];
               bzero_d = (b == {n{1'b0}});
               bmag_d  = mag_n(b);
               r_d     = r;
               rem_d   = {(n+1){1'b0}};
               acc_d   = {(2*n){1'b0}};
               busy_d  = 1'b1;
               state_d = S_RUN;
               if (|signal) begin
                  shf_d = mag_2n({m, r});
                  cnt_d = CNT_MUL;
               end else begin
                  // Multiplier |m| sits in the top half so it is consumed MSB first.
                  shf_d = {mag_n(m), {n{1'b0}}};
                  cnt_d = CNT_DIV;
               end
            end else begin
               state_d = S_IDLE;
            end
         end

         S_RUN: begin
            if (mode_q) begin
               // Restoring step: quotient bit enters at the LSB as dividend bits leave the MSB.
               if (trial_s >= {1'b0, bmag_q}) begin
                  rem_d = trial_s - {1'b0, bmag_q};
                  shf_d = {shf_q[2*n-2:0], 1'b1};
               end else begin
                  rem_d = trial_s;
                  shf_d = {shf_q[2*n-2:0], 1'b0};
               end
            end else begin
               // MSB-first shift-add: acc = 2*acc + bit*|b|.
               if (shf_q[2*n-1]) begin
                  acc_d = {acc_q[2*n-2:0], 1'b0} + {{n{1'b0}}, bmag_q};
               end else begin
                  acc_d = {acc_q[2*n-2:0], 1'b0};
               end
               shf_d = {shf_q[2*n-2:0], 1'b0};
            end
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
               state_d = S_FIN;
            end else begin
               state_d = S_RUN;
            end
         end

         S_FIN: begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
            if (bzero_q) begin
               a_d   = {n{1'b0}};
               err_d = 1'b1;
               ovf_d = 1'b0;
               inx_d = 1'b0;
            end else if (mode_q) begin
               a_d   = quo_s[n-1:0];
               err_d = 1'b0;
               ovf_d = ~fits_n(quo_s);
               inx_d = (rem_q != {(n+1){1'b0}});
            end else begin
               a_d   = sum_s[n-1:0];
               err_d = 1'b0;
               ovf_d = ~fits_n(sum_s);
               // Truncated division: remainder magnitude below |b|, sign follows the dividend.
               inx_d = (rmag_s >= bmag_q) |
                       ((r_q != {n{1'b0}}) & (r_q[n-1] != sum_s[2*n]));
            end
         end

         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         mode_q  <= 1'b0;
         neg_q   <= 1'b0;
         bzero_q <= 1'b0;
         bmag_q  <= {n{1'b0}};
         r_q     <= {n{1'b0}};
         shf_q   <= {(2*n){1'b0}};
         rem_q   <= {(n+1){1'b0}};
         acc_q   <= {(2*n){1'b0}};
         cnt_q   <= {CW{1'b0}};
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         a_q     <= {n{1'b0}};
         err_q   <= 1'b0;
         ovf_q   <= 1'b0;
         inx_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         neg_q   <= neg_d;
         bzero_q <= bzero_d;
         bmag_q  <= bmag_d;
         r_q     <= r_d;
         shf_q   <= shf_d;
         rem_q   <= rem_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         a_q     <= a_d;
         err_q   <= err_d;
         ovf_q   <= ovf_d;
         inx_q   <= inx_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign a_out    = a_q;
   assign error    = err_q;
   assign overflow = ovf_q;
   assign inexact  = inx_q;

endmodule
